// File: rtl/forward_tracker_pkg.sv
// Shared definitions for the operand-forwarding / hazard tracker.
// Holds the default geometry, the "read from register file" select code, the
// history-update action encoding and the select-width helper.
// Optional feature macro used by this slice: FWD_LOAD_STALL_EN.
package forward_tracker_pkg;

    localparam int FT_REG_NUM_WIDTH = 5;
    localparam int FT_READ_PORTS    = 2;
    localparam int FT_DEPTH         = 2;

    // Select code meaning "take the operand from the register file".
    localparam int FWD_SEL_REG_FILE = 0;

    // History update action for one clock edge, highest priority first.
    typedef enum logic [1:0] {
        UPD_FLUSH  = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2,
        UPD_SHIFT  = 2'd3
    } upd_e;

    // Width needed to encode 0 (register file) plus DEPTH producer stages.
    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/forward_tracker_if.sv
// Decode/execute-side bundle for the forwarding tracker.
// master: the pipeline control that issues instructions and reads selects.
// slave : the tracker itself.
//   flush, hold         pipeline redirect / downstream stall
//   regWriteNum/En      destination of the instruction issuing this cycle
//   isLoad              issuing instruction is a load
//   regReadNum          source indices, port r at [r*W +: W]
//   forwardSel          per-port select, 0 = register file, k = k stages ahead
//   loadUseStall        request for one bubble
interface forward_tracker_if
    import forward_tracker_pkg::*;
#(
    parameter int REG_NUM_WIDTH = FT_REG_NUM_WIDTH,
    parameter int READ_PORTS    = FT_READ_PORTS,
    parameter int DEPTH         = FT_DEPTH
) ();

    localparam int SEL_WIDTH = fwd_sel_width(DEPTH);

    logic                                flush;
    logic                                hold;
    logic [REG_NUM_WIDTH-1:0]            regWriteNum;
    logic                                regWriteEn;
    logic                                isLoad;
    logic [READ_PORTS*REG_NUM_WIDTH-1:0] regReadNum;
    logic [READ_PORTS*SEL_WIDTH-1:0]     forwardSel;
    logic                                loadUseStall;

    modport master (
        output flush, hold, regWriteNum, regWriteEn, isLoad, regReadNum,
        input  forwardSel, loadUseStall
    );

    modport slave (
        input  flush, hold, regWriteNum, regWriteEn, isLoad, regReadNum,
        output forwardSel, loadUseStall
    );

endinterface

// File: rtl/forward_tracker_match.sv
// Priority matcher for one read port against the flattened producer history.
//   read_num    source register index of this port
//   hist_valid  valid bit per entry, bit 0 = newest
//   hist_num    destination per entry, entry k at [k*W +: W]
//   hit         some valid entry produces read_num (never for x0)
//   sel         1-based distance of the newest matching producer, 0 if none
module fwd_match
    import forward_tracker_pkg::*;
#(
    parameter int REG_NUM_WIDTH = FT_REG_NUM_WIDTH,
    parameter int DEPTH         = FT_DEPTH,
    parameter int SEL_WIDTH     = fwd_sel_width(DEPTH)
) (
    input  logic [REG_NUM_WIDTH-1:0]       read_num,
    input  logic [DEPTH-1:0]               hist_valid,
    input  logic [DEPTH*REG_NUM_WIDTH-1:0] hist_num,
    output logic                           hit,
    output logic [SEL_WIDTH-1:0]           sel
);

    // Scan oldest to newest so the newest match is the one left standing.
    always_comb begin
        hit = 1'b0;
        sel = SEL_WIDTH'(FWD_SEL_REG_FILE);
        if (read_num != {REG_NUM_WIDTH{1'b0}}) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hist_valid[k] &&
                    (hist_num[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] == read_num)) begin
                    hit = 1'b1;
                    sel = SEL_WIDTH'(k + 1);
                end else begin
                    hit = hit;
                    sel = sel;
                end
            end
        end else begin
            hit = 1'b0;
            sel = SEL_WIDTH'(FWD_SEL_REG_FILE);
        end
    end

endmodule

// File: rtl/forward_tracker.sv
// Operand-forwarding and load-use hazard tracker for the pipelined RV32 core.
// Keeps the destinations of the last DEPTH issued instructions and, with zero
// latency, tells the execute-stage operand muxes where each source comes from.
//   clk, rst_n  core clock (rising edge), asynchronous active-low reset
//   bus         forward_tracker_if.slave (see interface header)
// Feature macro FWD_LOAD_STALL_EN: when defined, a consumer directly behind a
// load raises loadUseStall and gets select 0; when undefined loads forward
// like ALU results, the load bit is not stored and loadUseStall is tied low.
module forward_tracker
    import forward_tracker_pkg::*;
#(
    parameter int REG_NUM_WIDTH = FT_REG_NUM_WIDTH,
    parameter int READ_PORTS    = FT_READ_PORTS,
    parameter int DEPTH         = FT_DEPTH,
    parameter int SEL_WIDTH     = fwd_sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    forward_tracker_if.slave bus
);

    localparam int W = REG_NUM_WIDTH;

    // Index 0 is the newest entry (hist[1] in pipeline terms).
    logic [DEPTH-1:0]                  hist_valid_r;
    logic [DEPTH-1:0][W-1:0]           hist_num_r;

    logic                              new_valid_s;
    logic [READ_PORTS-1:0]             load_hit_s;
    logic                              stall_s;
    upd_e                              upd_s;
    logic [READ_PORTS-1:0]             match_hit_s;
    logic [READ_PORTS-1:0][SEL_WIDTH-1:0] match_sel_s;
    logic [READ_PORTS-1:0][SEL_WIDTH-1:0] fwd_sel_s;

    // x0 is hard-wired zero, so it is never recorded as a producer.
    assign new_valid_s = bus.regWriteEn && (bus.regWriteNum != {W{1'b0}});

    genvar r;
    generate
        for (r = 0; r < READ_PORTS; r++) begin : g_port
            fwd_match #(
                .REG_NUM_WIDTH (W),
                .DEPTH         (DEPTH),
                .SEL_WIDTH     (SEL_WIDTH)
            ) u_match (
                .read_num   (bus.regReadNum[r*W +: W]),
                .hist_valid (hist_valid_r),
                .hist_num   (hist_num_r),
                .hit        (match_hit_s[r]),
                .sel        (match_sel_s[r])
            );
        end
    endgenerate

`ifdef FWD_LOAD_STALL_EN
    logic [DEPTH-1:0] hist_load_r;

    // A load result is not ready one stage ahead: flag ports reading it.
    always_comb begin
        load_hit_s = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            if (hist_valid_r[0] && hist_load_r[0] &&
                (bus.regReadNum[p*W +: W] != {W{1'b0}}) &&
                (bus.regReadNum[p*W +: W] == hist_num_r[0])) begin
                load_hit_s[p] = 1'b1;
            end else begin
                load_hit_s[p] = 1'b0;
            end
        end
    end

    // Load-flag history follows the same update rules as the main history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_load_r <= {DEPTH{1'b0}};
        end else begin
            case (upd_s)
                UPD_FLUSH,
                UPD_HOLD: begin
                    hist_load_r <= hist_load_r;
                end
                UPD_BUBBLE: begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        hist_load_r[k] <= hist_load_r[k-1];
                    end
                    hist_load_r[0] <= 1'b0;
                end
                UPD_SHIFT: begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        hist_load_r[k] <= hist_load_r[k-1];
                    end
                    hist_load_r[0] <= bus.isLoad;
                end
                default: begin
                    hist_load_r <= {DEPTH{1'b0}};
                end
            endcase
        end
    end
`else
    logic unused_load_s;

    assign load_hit_s    = {READ_PORTS{1'b0}};
    assign unused_load_s = bus.isLoad;
`endif

    assign stall_s = |load_hit_s;

    // Edge action priority: flush > hold > load-use bubble > normal shift.
    always_comb begin
        upd_s = UPD_SHIFT;
        if (bus.flush) begin
            upd_s = UPD_FLUSH;
        end else if (bus.hold) begin
            upd_s = UPD_HOLD;
        end else if (stall_s) begin
            upd_s = UPD_BUBBLE;
        end else begin
            upd_s = UPD_SHIFT;
        end
    end

    // Producer history: valid bits and destination indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid_r <= {DEPTH{1'b0}};
            hist_num_r   <= {(DEPTH*W){1'b0}};
        end else begin
            case (upd_s)
                UPD_FLUSH: begin
                    hist_valid_r <= {DEPTH{1'b0}};
                    hist_num_r   <= hist_num_r;
                end
                UPD_HOLD: begin
                    hist_valid_r <= hist_valid_r;
                    hist_num_r   <= hist_num_r;
                end
                UPD_BUBBLE: begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        hist_valid_r[k] <= hist_valid_r[k-1];
                        hist_num_r[k]   <= hist_num_r[k-1];
                    end
                    hist_valid_r[0] <= 1'b0;
                    hist_num_r[0]   <= {W{1'b0}};
                end
                UPD_SHIFT: begin
                    for (int k = DEPTH - 1; k > 0; k--) begin
                        hist_valid_r[k] <= hist_valid_r[k-1];
                        hist_num_r[k]   <= hist_num_r[k-1];
                    end
                    hist_valid_r[0] <= new_valid_s;
                    hist_num_r[0]   <= bus.regWriteNum;
                end
                default: begin
                    hist_valid_r <= {DEPTH{1'b0}};
                    hist_num_r   <= hist_num_r;
                end
            endcase
        end
    end

    // Ports stalled on a load must read the register file this cycle.
    always_comb begin
        fwd_sel_s = {(READ_PORTS*SEL_WIDTH){1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            if (match_hit_s[p] && !load_hit_s[p]) begin
                fwd_sel_s[p] = match_sel_s[p];
            end else begin
                fwd_sel_s[p] = SEL_WIDTH'(FWD_SEL_REG_FILE);
            end
        end
    end

    assign bus.forwardSel   = fwd_sel_s;
    assign bus.loadUseStall = stall_s;

endmodule

// File: tb/tb_forward_tracker.sv
module tb_forward_tracker;

    localparam int W  = 5;
    localparam int RP = 2;
    localparam int D  = 2;
    localparam int SW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    forward_tracker_if #(.REG_NUM_WIDTH(W), .READ_PORTS(RP), .DEPTH(D)) bus_if ();

    forward_tracker #(.REG_NUM_WIDTH(W), .READ_PORTS(RP), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Reference history: queue of in-flight producers, element 0 is newest.
    typedef struct packed {
        logic         v;
        logic [W-1:0] n;
        logic         ld;
    } ent_t;

    ent_t hq[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [SW-1:0] obs_sel0;
    logic [SW-1:0] obs_sel1;
    logic          obs_stall;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic void model_reset();
        ent_t e;
        e = '0;
        hq.delete();
        for (int i = 0; i < D; i++) hq.push_back(e);
    endfunction

    // A port stalls when it reads the destination of a load issued last cycle.
    function automatic logic port_stall(input logic [W-1:0] rn);
`ifdef FWD_LOAD_STALL_EN
        return (rn != 0) && hq[0].v && hq[0].ld && (hq[0].n == rn);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [SW-1:0] model_sel(input logic [W-1:0] rn);
        if (rn == 0) return '0;
        if (port_stall(rn)) return '0;
        for (int i = 0; i < hq.size(); i++) begin
            if (hq[i].v && hq[i].n == rn) return SW'(i + 1);
        end
        return '0;
    endfunction

    // One cycle: drive, check outputs mid-cycle against the model, clock, update model.
    task automatic cyc(input logic fl, input logic ho, input logic [W-1:0] wn,
                       input logic we, input logic ld,
                       input logic [W-1:0] r0, input logic [W-1:0] r1,
                       input string tag);
        logic          e_stall;
        logic [SW-1:0] e0;
        logic [SW-1:0] e1;
        ent_t          e;
        bus_if.flush       = fl;
        bus_if.hold        = ho;
        bus_if.regWriteNum = wn;
        bus_if.regWriteEn  = we;
        bus_if.isLoad      = ld;
        bus_if.regReadNum  = {r1, r0};
        #2;
        e_stall   = port_stall(r0) | port_stall(r1);
        e0        = model_sel(r0);
        e1        = model_sel(r1);
        obs_sel0  = bus_if.forwardSel[0 +: SW];
        obs_sel1  = bus_if.forwardSel[SW +: SW];
        obs_stall = bus_if.loadUseStall;
        chk({tag, "_sel0"}, 8'(obs_sel0), 8'(e0));
        chk({tag, "_sel1"}, 8'(obs_sel1), 8'(e1));
        chk({tag, "_stall"}, 8'(obs_stall), 8'(e_stall));
        @(posedge clk);
        if (fl) begin
            foreach (hq[i]) hq[i].v = 1'b0;
        end else if (ho) begin
            e = '0;
        end else if (e_stall) begin
            e = '0;
            hq.push_front(e);
            void'(hq.pop_back());
        end else begin
            e.v  = we && (wn != 0);
            e.n  = wn;
            e.ld = ld;
            hq.push_front(e);
            void'(hq.pop_back());
        end
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.hold        = 1'b0;
        bus_if.regWriteNum = '0;
        bus_if.regWriteEn  = 1'b0;
        bus_if.isLoad      = 1'b0;
        bus_if.regReadNum  = {5'd5, 5'd5};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 8'(bus_if.forwardSel), 8'd0);
        chk("rst_stall", 8'(bus_if.loadUseStall), 8'd0);
        bus_if.hold = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) forwarding distance grows, then the producer ages out
        cyc(1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, "t1_issue");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, "t1_a");
        chk("t1_dist1", 8'(obs_sel0), 8'd1);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, "t1_b");
        chk("t1_dist2", 8'(obs_sel0), 8'd2);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, "t1_c");
        chk("t1_gone", 8'(obs_sel0), 8'd0);

        // 2) newest producer wins
        cyc(1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, "t2_w1");
        cyc(1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, "t2_w2");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, "t2_rd");
        chk("t2_newest", 8'(obs_sel0), 8'd1);

        // 3) x0 and write-disabled producers never forward
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, "t3_wx0");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, "t3_rx0");
        chk("t3_x0", 8'(obs_sel0), 8'd0);
        cyc(1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 5'd0, "t3_w9");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd9, "t3_r9");
        chk("t3_noen", 8'(obs_sel1), 8'd0);

        // 4) load-use
        cyc(1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, "t4_lw");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, "t4_use");
`ifdef FWD_LOAD_STALL_EN
        chk("t4_stall", 8'(obs_stall), 8'd1);
        chk("t4_sel_st", 8'(obs_sel0), 8'd0);
`else
        chk("t4_stall", 8'(obs_stall), 8'd0);
        chk("t4_sel_st", 8'(obs_sel0), 8'd1);
`endif
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, "t4_again");
        chk("t4_stall2", 8'(obs_stall), 8'd0);
        chk("t4_sel2", 8'(obs_sel0), 8'd2);

        // 5) flush clears history, also when hold is high
        cyc(1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, "t5_w1");
        cyc(1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, "t5_w2");
        cyc(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'd4, 5'd0, "t5_fl");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd4, "t5_rd");
        chk("t5_flushed", 8'(obs_sel0), 8'd0);
        cyc(1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, "t5_w3");
        cyc(1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, "t5_flh");
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0, "t5_rd2");
        chk("t5_flush_hold", 8'(obs_sel0), 8'd0);

        // 6) hold freezes history; async reset mid-hold clears it
        cyc(1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, "t6_w");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 5'd0, "t6_hold");
            chk("t6_held", 8'(obs_sel0), 8'd1);
        end
        bus_if.regReadNum = {5'd0, 5'd6};
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_sel", 8'(bus_if.forwardSel), 8'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 6b) reset asserted while a load-use stall is pending
        cyc(1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, "t6b_lw");
        bus_if.hold       = 1'b1;
        bus_if.regReadNum = {5'd0, 5'd3};
        #2;
`ifdef FWD_LOAD_STALL_EN
        chk("t6b_pre", 8'(bus_if.loadUseStall), 8'd1);
`else
        chk("t6b_pre", 8'(bus_if.forwardSel[0 +: SW]), 8'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("t6b_stall", 8'(bus_if.loadUseStall), 8'd0);
        chk("t6b_sel", 8'(bus_if.forwardSel), 8'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic over a small register set to provoke collisions
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
